// File: rtl/ahb_decode_ctrl.sv
// AHB-lite address decoder and data-phase controller for a 3-slave read-response mux.
// The block decodes haddr into slave selects and registers the data-phase mux select.
// It acts as the default slave and gives a two-cycle ERROR for unmapped active transfers.
// It forms the bus hready/hresp and runs a sticky wait-state watchdog.
module ahb_decode_ctrl #(
    parameter logic [3:0] S1_BASE = 4'h0,
    parameter logic [3:0] S2_BASE = 4'h1,
    parameter logic [3:0] S3_BASE = 4'h2,
    parameter int         TIMEOUT = 16
) (
    input  logic        hclk,
    input  logic        hreset,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        mux_hreadyout,
    input  logic [1:0]  mux_hresp,
    input  logic        timeout_clr,
    output logic        hsel_1,
    output logic        hsel_2,
    output logic        hsel_3,
    output logic [2:0]  sel,
    output logic        hready,
    output logic [1:0]  hresp,
    output logic        timeout_err
);

    localparam int         CNT_W      = $clog2(TIMEOUT + 1);
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE = 2'd0,
        DS_ERR1 = 2'd1,
        DS_ERR2 = 2'd2
    } ds_state_t;

    ds_state_t        state;
    ds_state_t        state_next;
    logic [2:0]       sel_next;
    logic             ds_hready;
    logic [1:0]       ds_hresp;
    logic [3:0]       region;
    logic             active;
    logic             unmapped;
    logic             wait_cycle;
    logic             wdog_hit;
    logic [CNT_W-1:0] wdog_cnt;

    assign region     = haddr[31:28];
    assign active     = htrans[1];
    assign unmapped   = ~(hsel_1 | hsel_2 | hsel_3);
    // A wait cycle is a data phase owned by a real slave that is stretching the transfer.
    assign wait_cycle = (sel != 3'b000) && !mux_hreadyout;
    // The flag is raised on the wait cycle that takes the counter to TIMEOUT.
    assign wdog_hit   = wait_cycle && (wdog_cnt == CNT_W'(TIMEOUT - 1));

    // Address-phase decode; priority order keeps at most one select high even if bases overlap.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        hsel_1 = 1'b0;
        hsel_2 = 1'b0;
        hsel_3 = 1'b0;
        if (!hreset) begin
            if (region == S1_BASE)      hsel_1 = 1'b1;
            else if (region == S2_BASE) hsel_2 = 1'b1;
            else if (region == S3_BASE) hsel_3 = 1'b1;
        end
    end

    // Next data-phase select: only a completed (hready=1) cycle lets a new transfer in.
    always_comb begin
        sel_next = sel;
        if (hready) begin
            sel_next = 3'b000;
            if (active) begin
                if (hsel_1)      sel_next = 3'b001;
                else if (hsel_2) sel_next = 3'b010;
                else if (hsel_3) sel_next = 3'b011;
            end
        end
    end

    // Data-phase select register.
    always_ff @(posedge hclk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (hreset) sel <= 3'b000;
        else        sel <= sel_next;
    end

    // Default-slave response driven purely by its state; kept apart from next-state to avoid a loop through hready.
    always_comb begin
        ds_hready = 1'b1;
        ds_hresp  = RESP_OKAY;
        case (state)
            DS_ERR1: begin
                ds_hready = 1'b0;
                ds_hresp  = RESP_ERROR;
            end
            DS_ERR2: begin
                ds_hready = 1'b1;
                ds_hresp  = RESP_ERROR;
            end
            default: begin
                ds_hready = 1'b1;
                ds_hresp  = RESP_OKAY;
            end
        endcase
    end

    // Bus response mux: a selected slave owns the bus, otherwise the default slave answers.
    always_comb begin
        hready = ds_hready;
        hresp  = ds_hresp;
        if (sel != 3'b000) begin
            hready = mux_hreadyout;
            hresp  = mux_hresp;
        end
    end

    // Default-slave next state: accept unmapped active transfers on any ready cycle, including ERR2.
    always_comb begin
        state_next = state;
        case (state)
            DS_IDLE: if (hready && active && unmapped) state_next = DS_ERR1;
            DS_ERR1: state_next = DS_ERR2;
            DS_ERR2: state_next = (active && unmapped) ? DS_ERR1 : DS_IDLE;
            default: state_next = DS_IDLE;
        endcase
    end

    // Default-slave state register; reset aborts any error response in flight.
    always_ff @(posedge hclk) begin
        if (hreset) state <= DS_IDLE;
        else        state <= state_next;
    end

    // Watchdog counter: counts consecutive slave wait cycles, saturating, cleared by any ready cycle.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            wdog_cnt <= '0;
        end else if (hready) begin
            wdog_cnt <= '0;
        end else if (wait_cycle && (wdog_cnt != CNT_W'(TIMEOUT))) begin
            wdog_cnt <= wdog_cnt + CNT_W'(1);
        end
    end

    // Sticky timeout flag; a coincident set beats the clear, and clearing leaves the counter alone.
    always_ff @(posedge hclk) begin
        if (hreset)           timeout_err <= 1'b0;
        else if (wdog_hit)    timeout_err <= 1'b1;
        else if (timeout_clr) timeout_err <= 1'b0;
    end

endmodule

// File: tb/tb_ahb_decode_ctrl.sv
// Self-checking bench for ahb_decode_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a transaction-level model.
module tb_ahb_decode_ctrl;

    localparam int TO = 4;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        mux_hreadyout;
    logic [1:0]  mux_hresp;
    logic        timeout_clr;
    logic        hsel_1, hsel_2, hsel_3;
    logic [2:0]  sel;
    logic        hready;
    logic [1:0]  hresp;
    logic        timeout_err;

    int vectors     = 0;
    int miscompares = 0;

    // Model state: who owns the data phase (0 none, 1..3 slave), error-response stage (0/1/2),
    // consecutive wait count and the sticky flag.
    int m_owner;
    int m_err;
    int m_cnt;
    bit m_terr;
    bit model_valid = 1'b0;

    ahb_decode_ctrl #(
        .S1_BASE(4'h0), .S2_BASE(4'h1), .S3_BASE(4'h2), .TIMEOUT(TO)
    ) dut (
        .hclk(hclk), .hreset(hreset), .haddr(haddr), .htrans(htrans),
        .mux_hreadyout(mux_hreadyout), .mux_hresp(mux_hresp), .timeout_clr(timeout_clr),
        .hsel_1(hsel_1), .hsel_2(hsel_2), .hsel_3(hsel_3), .sel(sel),
        .hready(hready), .hresp(hresp), .timeout_err(timeout_err)
    );

    always #5 hclk = ~hclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int region_slave(input logic [31:0] a);
        case (a[31:28])
            4'h0:    return 1;
            4'h1:    return 2;
            4'h2:    return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic model_hready();
        if (m_owner != 0) return mux_hreadyout;
        return (m_err != 1);
    endfunction

    function automatic logic [1:0] model_hresp();
        if (m_owner != 0) return mux_hresp;
        return (m_err != 0) ? 2'b01 : 2'b00;
    endfunction

    // Advance the model by one bus cycle using the inputs present before the edge.
    always @(posedge hclk) begin
        bit hr;
        bit wt;
        int tgt;
        if (hreset) begin
            m_owner     = 0;
            m_err       = 0;
            m_cnt       = 0;
            m_terr      = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            hr = model_hready();
            wt = (m_owner != 0) && !mux_hreadyout;
            if (wt && m_cnt == TO - 1) m_terr = 1'b1;
            else if (timeout_clr)      m_terr = 1'b0;
            if (hr)                    m_cnt = 0;
            else if (wt && m_cnt < TO) m_cnt = m_cnt + 1;
            if (hr) begin
                tgt     = region_slave(haddr);
                m_owner = htrans[1] ? tgt : 0;
                m_err   = (htrans[1] && tgt == 0) ? 1 : 0;
            end else if (m_err == 1) begin
                m_err = 2;
            end
        end
    end

    // Compare every output against the model mid-cycle.
    always @(negedge hclk) begin
        check("hsel_1", 32'(hsel_1), 32'(!hreset && region_slave(haddr) == 1));
        check("hsel_2", 32'(hsel_2), 32'(!hreset && region_slave(haddr) == 2));
        check("hsel_3", 32'(hsel_3), 32'(!hreset && region_slave(haddr) == 3));
        if (model_valid) begin
            check("sel",         32'(sel),         32'(m_owner));
            check("hready",      32'(hready),      32'(model_hready()));
            check("hresp",       32'(hresp),       32'(model_hresp()));
            check("timeout_err", 32'(timeout_err), 32'(m_terr));
        end
    end

    task automatic drive(input logic rst, input logic [31:0] a, input logic [1:0] t,
                         input logic rdy, input logic [1:0] rsp, input logic clr);
        hreset        = rst;
        haddr         = a;
        htrans        = t;
        mux_hreadyout = rdy;
        mux_hresp     = rsp;
        timeout_clr   = clr;
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    initial begin
        drive(1'b1, 32'h0000_0010, 2'b10, 1'b1, 2'b00, 1'b0);

        // T1: reset with an active transfer presented
        tick();
        @(negedge hclk);
        check("T1 sel", 32'(sel), 32'h0);
        check("T1 hready", 32'(hready), 32'h1);
        check("T1 hresp", 32'(hresp), 32'h0);
        check("T1 hsel_1", 32'(hsel_1), 32'h0);
        tick();

        // T2: mapped NONSEQ to slave 2 with two wait states
        drive(1'b0, 32'h1000_0004, 2'b10, 1'b1, 2'b00, 1'b0);
        @(negedge hclk);
        check("T2 hsel_2", 32'(hsel_2), 32'h1);
        tick();
        drive(1'b0, 32'h0000_0000, 2'b00, 1'b0, 2'b00, 1'b0);
        @(negedge hclk);
        check("T2 sel", 32'(sel), 32'h2);
        check("T2 hready w1", 32'(hready), 32'h0);
        tick();
        @(negedge hclk);
        check("T2 hready w2", 32'(hready), 32'h0);
        tick();
        mux_hreadyout = 1'b1;
        @(negedge hclk);
        check("T2 hready done", 32'(hready), 32'h1);
        tick();
        @(negedge hclk);
        check("T2 sel after", 32'(sel), 32'h0);

        // T3: single unmapped NONSEQ
        drive(1'b0, 32'h8000_0000, 2'b10, 1'b1, 2'b00, 1'b0);
        tick();
        htrans = 2'b00;
        @(negedge hclk);
        check("T3 c1", {30'h0, hready, hresp}, {30'h0, 1'b0, 2'b01});
        tick();
        @(negedge hclk);
        check("T3 c2", {30'h0, hready, hresp}, {30'h0, 1'b1, 2'b01});
        tick();
        @(negedge hclk);
        check("T3 c3", {30'h0, hready, hresp}, {30'h0, 1'b1, 2'b00});

        // T4: back-to-back unmapped NONSEQ, second accepted in ERR2
        drive(1'b0, 32'h9000_0000, 2'b10, 1'b1, 2'b00, 1'b0);
        tick();
        @(negedge hclk);
        check("T4 c1", {30'h0, hready, hresp}, {30'h0, 1'b0, 2'b01});
        tick();
        @(negedge hclk);
        check("T4 c2", {30'h0, hready, hresp}, {30'h0, 1'b1, 2'b01});
        tick();
        htrans = 2'b00;
        @(negedge hclk);
        check("T4 c3", {30'h0, hready, hresp}, {30'h0, 1'b0, 2'b01});
        tick();
        @(negedge hclk);
        check("T4 c4", {30'h0, hready, hresp}, {30'h0, 1'b1, 2'b01});
        tick();

        // T5: slave 3 stalls 6 cycles; set/clear collision, then clear alone
        drive(1'b0, 32'h2000_0000, 2'b10, 1'b1, 2'b00, 1'b0);
        tick();
        drive(1'b0, 32'h0000_0000, 2'b00, 1'b0, 2'b00, 1'b0);
        for (int w = 1; w <= 6; w++) begin
            timeout_clr = (w == 4);
            @(negedge hclk);
            check("T5 sel", 32'(sel), 32'h3);
            check("T5 terr", 32'(timeout_err), (w >= 5) ? 32'h1 : 32'h0);
            tick();
        end
        timeout_clr   = 1'b0;
        mux_hreadyout = 1'b1;
        tick();
        @(negedge hclk);
        check("T5 terr held", 32'(timeout_err), 32'h1);
        timeout_clr = 1'b1;
        tick();
        timeout_clr = 1'b0;
        @(negedge hclk);
        check("T5 terr cleared", 32'(timeout_err), 32'h0);

        // T6: reset during ERR1
        drive(1'b0, 32'hF000_0000, 2'b10, 1'b1, 2'b00, 1'b0);
        tick();
        @(negedge hclk);
        check("T6 err1", 32'(hready), 32'h0);
        hreset = 1'b1;
        tick();
        drive(1'b0, 32'h0000_0000, 2'b00, 1'b0, 2'b00, 1'b0);
        @(negedge hclk);
        check("T6 sel", 32'(sel), 32'h0);
        check("T6 resp", {30'h0, hready, hresp}, {30'h0, 1'b1, 2'b00});
        tick();

        // Randomized traffic; slave readiness bias varies per segment to reach the watchdog.
        for (int seg = 0; seg < 10; seg++) begin
            int rdy_pct;
            rdy_pct = (seg % 2 == 0) ? 75 : 25;
            for (int c = 0; c < 200; c++) begin
                hreset        = ($urandom_range(0, 99) == 0);
                haddr         = {4'($urandom_range(0, 4)), 28'($urandom)};
                htrans        = 2'($urandom_range(0, 3));
                mux_hreadyout = ($urandom_range(0, 99) < rdy_pct);
                mux_hresp     = 2'($urandom_range(0, 1));
                timeout_clr   = ($urandom_range(0, 7) == 0);
                tick();
            end
        end

        @(negedge hclk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
